// File: rtl/handshake_fifo_responder.sv
// FIFO-buffered responder for the req/ack dataflow protocol: words pushed on the
// write port are handed out one per registered ack pulse once every req line is high.
module handshake_fifo_responder #(
  parameter int data_width    = 32,
  parameter int depth         = 16,
  parameter int num_consumers = 1,
  parameter int responder_id  = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [data_width-1:0]    wr_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(depth):0]   level,
  input  logic [num_consumers-1:0] req,
  output logic                     ack,
  output logic [data_width-1:0]    dout,
  output logic [31:0]              count,
  output logic [31:0]              overflow_count
);

  localparam int AW = (depth > 1) ? $clog2(depth) : 1;
  localparam int LW = AW + 1;

  if ((depth < 2) || ((depth & (depth - 1)) != 0)) begin : g_bad_depth
    $error("handshake_fifo_responder: depth must be a power of two >= 2");
  end
  if (num_consumers < 1) begin : g_bad_consumers
    $error("handshake_fifo_responder: num_consumers must be >= 1");
  end
  if (responder_id < 0) begin : g_bad_id
    $error("handshake_fifo_responder: responder_id must be non-negative");
  end

  logic [data_width-1:0] mem [depth];

  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]         level_q, level_d;
  logic                  ack_q, ack_d;
  logic [data_width-1:0] dout_q, dout_d;
  logic [31:0]           count_q, count_d;
  logic [31:0]           ovf_q, ovf_d;

  logic req_all;
  logic push;
  logic fire;

  // Status comes from registered occupancy only, so wr_en/req never reach an output.
  assign full           = (level_q == LW'(depth));
  assign empty          = (level_q == '0);
  assign level          = level_q;
  assign ack            = ack_q;
  assign dout           = dout_q;
  assign count          = count_q;
  assign overflow_count = ovf_q;

  assign req_all = &req;
  assign push    = wr_en & ~full;
  assign fire    = req_all & ~ack_q & ~empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    ack_d    = fire;
    dout_d   = dout_q;
    count_d  = count_q;
    ovf_d    = ovf_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else if (wr_en) begin
      ovf_d = ovf_q + 32'd1;
    end

    // dout only moves on the edge where ack rises; consumers latch on posedge ack.
    if (fire) begin
      dout_d   = mem[rd_ptr_q];
      rd_ptr_d = rd_ptr_q + AW'(1);
      count_d  = count_q + 32'd1;
    end

    case ({push, fire})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ack_q    <= 1'b0;
      dout_q   <= '0;
      count_q  <= '0;
      ovf_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ack_q    <= ack_d;
      dout_q   <= dout_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage is never cleared; stale words are unreachable once the pointers reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= wr_data;
    end
  end

endmodule

// File: tb/tb_handshake_fifo_responder.sv
// Directed bench for handshake_fifo_responder: a depth-16 single-consumer instance
// and a depth-4 three-consumer instance sharing clock and reset.
module tb_handshake_fifo_responder;

  logic        clk;
  logic        rst;

  logic        wr_en_a;
  logic [31:0] wr_data_a;
  logic        full_a, empty_a;
  logic [4:0]  level_a;
  logic [0:0]  req_a;
  logic        ack_a;
  logic [31:0] dout_a, count_a, ovf_a;

  logic        wr_en_b;
  logic [31:0] wr_data_b;
  logic        full_b, empty_b;
  logic [2:0]  level_b;
  logic [2:0]  req_b;
  logic        ack_b;
  logic [31:0] dout_b, count_b, ovf_b;

  int n_vec;
  int n_err;

  handshake_fifo_responder #(
    .data_width(32), .depth(16), .num_consumers(1), .responder_id(0)
  ) dut_a (
    .clk(clk), .rst(rst), .wr_en(wr_en_a), .wr_data(wr_data_a),
    .full(full_a), .empty(empty_a), .level(level_a), .req(req_a),
    .ack(ack_a), .dout(dout_a), .count(count_a), .overflow_count(ovf_a)
  );

  handshake_fifo_responder #(
    .data_width(32), .depth(4), .num_consumers(3), .responder_id(1)
  ) dut_b (
    .clk(clk), .rst(rst), .wr_en(wr_en_b), .wr_data(wr_data_b),
    .full(full_b), .empty(empty_b), .level(level_b), .req(req_b),
    .ack(ack_b), .dout(dout_b), .count(count_b), .overflow_count(ovf_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int got;
    int prev_ack;
    int sent;
    int recv;

    n_vec = 0;
    n_err = 0;
    rst = 1'b0;
    wr_en_a = 1'b0; wr_data_a = '0; req_a = '0;
    wr_en_b = 1'b0; wr_data_b = '0; req_b = '0;

    // Reset values
    tick();
    tick();
    chk("rst_ack", 32'(ack_a), 32'd0);
    chk("rst_dout", dout_a, 32'd0);
    chk("rst_count", count_a, 32'd0);
    chk("rst_ovf", ovf_a, 32'd0);
    chk("rst_level", 32'(level_a), 32'd0);
    chk("rst_empty", 32'(empty_a), 32'd1);
    chk("rst_full", 32'(full_a), 32'd0);
    chk("rst_b_empty", 32'(empty_b), 32'd1);

    // Single word: push at edge N, ack after edge N+1
    rst = 1'b1;
    wr_en_a = 1'b1; wr_data_a = 32'h0000_00AA; req_a = 1'b1;
    tick();
    wr_en_a = 1'b0;
    chk("single_level_after_push", 32'(level_a), 32'd1);
    chk("single_no_bypass_ack", 32'(ack_a), 32'd0);
    tick();
    chk("single_ack", 32'(ack_a), 32'd1);
    chk("single_dout", dout_a, 32'h0000_00AA);
    chk("single_count", count_a, 32'd1);
    chk("single_empty", 32'(empty_a), 32'd1);
    tick();
    chk("single_ack_width", 32'(ack_a), 32'd0);
    chk("single_dout_hold", dout_a, 32'h0000_00AA);

    // Ordering and throughput: push 0..9 back-to-back, req held high
    got = 0;
    prev_ack = -1;
    for (int c = 0; c < 40; c++) begin
      wr_en_a   = (c < 10);
      wr_data_a = 32'(c);
      tick();
      if (ack_a) begin
        chk("order_dout", dout_a, 32'(got));
        if (prev_ack >= 0) chk("order_spacing", 32'(c - prev_ack), 32'd2);
        prev_ack = c;
        got++;
      end
    end
    wr_en_a = 1'b0;
    chk("order_words", 32'(got), 32'd10);
    chk("order_count", count_a, 32'd11);
    chk("order_empty", 32'(empty_a), 32'd1);

    // Full and overflow on depth 4 with req low
    for (int i = 0; i < 6; i++) begin
      wr_en_b   = 1'b1;
      wr_data_b = 32'h100 + 32'(i);
      tick();
      if (i == 3) chk("full_after_4th", 32'(full_b), 32'd1);
      if (i == 2) chk("not_full_after_3rd", 32'(full_b), 32'd0);
    end
    wr_en_b = 1'b0;
    chk("ovf_count", ovf_b, 32'd2);
    chk("ovf_level", 32'(level_b), 32'd4);
    chk("ovf_no_ack", 32'(ack_b), 32'd0);
    req_b = 3'b111;
    got = 0;
    for (int c = 0; c < 20 && got < 4; c++) begin
      tick();
      if (ack_b) begin
        chk("drain_dout", dout_b, 32'h100 + 32'(got));
        got++;
      end
    end
    req_b = 3'b000;
    tick();
    chk("drain_words", 32'(got), 32'd4);
    chk("drain_count", count_b, 32'd4);
    chk("drain_empty", 32'(empty_b), 32'd1);

    // Join: two of three req lines high must not ack
    wr_en_b = 1'b1; wr_data_b = 32'h55; req_b = 3'b011;
    tick();
    wr_en_b = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("join_partial_no_ack", 32'(ack_b), 32'd0);
    end
    req_b = 3'b111;
    tick();
    chk("join_ack", 32'(ack_b), 32'd1);
    chk("join_dout", dout_b, 32'h55);
    req_b = 3'b000;
    tick();
    chk("join_count", count_b, 32'd5);

    // Wrap-around: 20 words through depth 4 with a random req duty
    sent = 0;
    recv = 0;
    for (int c = 0; c < 600 && recv < 20; c++) begin
      wr_en_b   = (sent < 20) && !full_b;
      wr_data_b = 32'h200 + 32'(sent);
      req_b     = ($urandom_range(0, 2) == 0) ? 3'b101 : 3'b111;
      if (wr_en_b) sent++;
      tick();
      chk("wrap_level_le4", 32'(level_b > 3'd4), 32'd0);
      if (ack_b) begin
        chk("wrap_dout", dout_b, 32'h200 + 32'(recv));
        recv++;
      end
    end
    wr_en_b = 1'b0;
    req_b   = 3'b000;
    chk("wrap_words", 32'(recv), 32'd20);
    chk("wrap_count", count_b, 32'd25);
    chk("wrap_ovf_kept", ovf_b, 32'd2);

    // Mid-run reset: pending words are lost, the stream restarts
    req_a = 1'b1;
    for (int i = 0; i < 6; i++) begin
      wr_en_a   = 1'b1;
      wr_data_a = 32'h300 + 32'(i);
      tick();
    end
    wr_en_a = 1'b0;
    rst = 1'b0;
    tick();
    chk("mrst_ack", 32'(ack_a), 32'd0);
    chk("mrst_count", count_a, 32'd0);
    chk("mrst_level", 32'(level_a), 32'd0);
    chk("mrst_dout", dout_a, 32'd0);
    chk("mrst_b_count", count_b, 32'd0);
    chk("mrst_b_ovf", ovf_b, 32'd0);
    rst = 1'b1;
    tick();
    chk("mrst_no_stale_ack", 32'(ack_a), 32'd0);
    chk("mrst_empty", 32'(empty_a), 32'd1);
    wr_en_a = 1'b1; wr_data_a = 32'h400;
    tick();
    wr_en_a = 1'b0;
    chk("restart_no_ack_yet", 32'(ack_a), 32'd0);
    tick();
    chk("restart_ack", 32'(ack_a), 32'd1);
    chk("restart_dout", dout_a, 32'h400);
    chk("restart_count", count_a, 32'd1);
    req_a = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/handshake_fifo_responder.md
# handshake_fifo_responder

Buffered responder for the req/ack dataflow protocol. It accepts words from a push-style write port into a FIFO, and serves them to one or more downstream `async_operator` input ports (or `consumer` benches) using the same registered one-cycle `ack` pulse the `producer` bench model uses. It sits at the boundary between a conventional streaming source and an `arf` graph input (`din_req_N`/`din_ack_N`/`din_N`), replacing the `producer` model when real data is fed in.

## Interface
Parameters:
- `data_width`, 32, width of data words.
- `depth`, 16, FIFO entries. Must be a power of two, ≥ 2.
- `num_consumers`, 1, number of request lines joined into one response. Must be ≥ 1.
- `responder_id`, 0, identifier only; no functional effect.

Ports:
- `clk`  input  1  system clock; all logic on the rising edge.
- `rst`  input  1  reset, synchronous, active-low (`rst == 0` resets).
- `wr_en`  input  1  push strobe for `wr_data`.
- `wr_data`  input  `data_width`  word to push.
- `full`  output  1  combinational, `level == depth`.
- `empty`  output  1  combinational, `level == 0`.
- `level`  output  `$clog2(depth)+1`  current occupancy.
- `req`  input  `num_consumers`  request from each downstream port.
- `ack`  output  1  registered response pulse, broadcast to all consumers.
- `dout`  output  `data_width`  registered data, valid from the rising edge of `ack`.
- `count`  output  32  number of words delivered (acks issued).
- `overflow_count`  output  32  number of pushes rejected while full.

## Operation
- Storage is a circular buffer with `wr_ptr` and `rd_ptr`, each `$clog2(depth)` bits. Pointers wrap modulo `depth`. `level` is kept as a separate counter.
- Push is accepted when `wr_en & ~full`. The word is written at `wr_ptr`, then `wr_ptr` is incremented.
- A push while full is dropped: storage and pointers are unchanged, and `overflow_count` increments (wraps at 2^32).
- The request join is `req_all = &req`. An ack fires when `req_all & ~ack & ~empty`.
- An ack fire does the following on the same edge:
  - `ack <= 1`
  - `dout <= mem[rd_ptr]`
  - `rd_ptr` increments
  - `count` increments
- Otherwise `ack <= 0`. `ack` is never high two cycles in a row, so the minimum spacing between acks is 2 cycles.
- `dout` holds its value until the next ack fire. Downstream latches on `posedge ack`, so `dout` must change only on the edge where `ack` rises.
- Simultaneous push and ack fire when `0 < level < depth`: both occur, and `level` is unchanged.
- When full, a push is rejected even if an ack fires in the same cycle. `full` is evaluated on pre-edge occupancy.
- When empty, a push in the same cycle does not enable an ack. The word is visible to the ack logic only from the next cycle; there is no bypass.
- `req` lines dropping mid-wait is legal. The ack simply does not fire until all lines are high again.
- Reset (`rst == 0`) at any cycle:
  - Pointers, `level`, `ack`, `count` and `overflow_count` go to 0.
  - `dout` goes to 0.
  - FIFO contents become don't-care and are not cleared.
  - A word already pushed before reset is lost. A pending ack is not issued.

## Timing
- Reset values: `ack=0`, `dout=0`, `count=0`, `overflow_count=0`, `level=0`, `empty=1`, `full=0`.
- Latency when empty: push at edge N gives `level=1` after N. If `req_all` is high, `ack=1` after edge N+1 with `dout = wr_data`. Minimum write-to-ack latency is 2 edges.
- Steady state with `req_all` held high and the FIFO non-empty: one word every 2 cycles. This matches `producer` throughput.
- `full`, `empty` and `level` reflect register state after the last edge. No combinational path exists from `wr_en` or `req` to any output.
- `ack` pulse width is exactly 1 cycle.

## Test plan
- **Reset and single word.** Hold `rst=0` for 2 cycles and check all outputs at reset values. Release, push `0x0000_00AA` once, hold `req=1`. Required: `ack` pulses 2 edges after the push with `dout=0xAA`, then `count=1`, `empty=1`.
- **Ordering and throughput.** Push 0..9 back-to-back, `req=1` constant. Required: `dout` sequence 0..9 in order, acks every 2nd cycle, final `count=10`.
- **Full and overflow, `depth=4`.** Push 6 words with `req=0`. Required: `full=1` after the 4th push and `overflow_count=2`. Raise `req`: words 0..3 are delivered, then `count=4`, `empty=1`.
- **Wrap-around.** With `depth=4`, run 20 words through with a random `req` duty. Required: in-order delivery across pointer wrap, and `level` never exceeds 4.
- **Join, `num_consumers=3`.** With the FIFO holding 1 word, set `req=3'b011` for 5 cycles. Required: no ack. Then set `req=3'b111`: ack fires next edge and is seen by all three.
- **Integration and mid-run reset.** Drive an `arf` graph's `din_*_0` port from this block with `consumer` on the output. Required: throughput matches the `producer`-driven run. Then pulse `rst=0` mid-stream: `ack` is low the next edge, `count=0`, and the stream restarts from the first post-reset push.
